// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver with integrated receive FIFO.
//   parity_mode_e : decoded parity selection
//   rx_state_e    : receiver FSM states
//   PRESCALE_MIN  : smallest usable clocks-per-bit value
//   TUSER_*       : bit positions of the error tags in m_axis_tuser
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreakWait
   } rx_state_e;

   localparam int unsigned PRESCALE_MIN = 4;

   localparam int unsigned TUSER_PARITY = 0;
   localparam int unsigned TUSER_FRAME  = 1;

   // The reserved encoding 2'b11 behaves as "no parity".
   function automatic parity_mode_e decode_parity(input logic [1:0] mode);
      case (mode)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a fall-through head.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i/wdata_i : write request and data; push_ok_o says whether it is taken this cycle
//   pop_ready_i    : consumer ready; a pop happens when valid_o && pop_ready_i
//   rdata_o        : head entry (zero while empty), valid_o : non-empty
//   count_o        : current occupancy
module uart_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic                     push_ok_o,
   input  logic                     pop_ready_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             pop, do_push;

   assign valid_o   = (count_q != '0);
   assign pop       = valid_o & pop_ready_i;
   // A full FIFO still takes a word if the head leaves in the same cycle.
   assign push_ok_o = (count_q != FullCount) | pop;
   assign do_push   = push_i & push_ok_o;
   assign rdata_o   = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o   = count_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime parity / stop-bit selection, per-word error tags, break
// detection and a fall-through receive FIFO presented as an AXI-Stream master.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   rx_i                  : asynchronous serial input, idle high
//   prescale_i            : clocks per bit (values below PRESCALE_MIN use PRESCALE_MIN)
//   parity_mode_i         : 00 none, 01 even, 10 odd, 11 none
//   stop_bits_i           : 0 one stop bit, 1 two stop bits
//   m_axis_*              : head word, {frame_err, parity_err} tags, valid, ready
//   busy_o                : receiver not idle
//   overrun/parity/frame_error_o, break_o : single-cycle event pulses
//   fifo_count_o          : FIFO occupancy
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned PRESCALE_WIDTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          rx_i,
   input  logic [PRESCALE_WIDTH-1:0]     prescale_i,
   input  logic [1:0]                    parity_mode_i,
   input  logic                          stop_bits_i,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [1:0]                    m_axis_tuser,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          busy_o,
   output logic                          overrun_error_o,
   output logic                          parity_error_o,
   output logic                          frame_error_o,
   output logic                          break_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int unsigned WordWidth = DATA_WIDTH + 2;
   localparam int unsigned PW        = PRESCALE_WIDTH;

   logic rx_meta_q, rx_s_q;

   rx_state_e             state_q, state_d;
   logic [PW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         prescale_q, prescale_d;
   parity_mode_e          parity_q, parity_d;
   logic                  two_stop_q, two_stop_d;
   logic [3:0]            bit_idx_q, bit_idx_d;
   logic                  stop_idx_q, stop_idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_bit_q, par_bit_d;
   logic                  par_err_q, par_err_d;
   logic                  frame_err_q, frame_err_d;

   logic                  sample, frame_err_now, push, brk, push_ok;
   logic [PW-1:0]         prescale_clamped;
   logic [WordWidth-1:0]  push_word, head_word;

   // Two-flop synchroniser; idles high so reset does not look like a start bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign prescale_clamped = (prescale_i < PW'(PRESCALE_MIN)) ? PW'(PRESCALE_MIN) : prescale_i;
   assign sample           = (cnt_q == '0);
   // Includes the stop sample being taken this cycle.
   assign frame_err_now    = frame_err_q | ~rx_s_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prescale_d  = prescale_q;
      parity_d    = parity_q;
      two_stop_d  = two_stop_q;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      shift_d     = shift_q;
      par_bit_d   = par_bit_q;
      par_err_d   = par_err_q;
      frame_err_d = frame_err_q;
      push        = 1'b0;
      brk         = 1'b0;

      if (state_q inside {StStart, StData, StParity, StStop}) begin
         cnt_d = sample ? prescale_q - PW'(1) : cnt_q - PW'(1);
      end

      case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               prescale_d  = prescale_clamped;
               parity_d    = decode_parity(parity_mode_i);
               two_stop_d  = stop_bits_i;
               // First sample lands mid start bit.
               cnt_d       = (prescale_clamped >> 1) - PW'(1);
               bit_idx_d   = '0;
               stop_idx_d  = 1'b0;
               par_bit_d   = 1'b0;
               par_err_d   = 1'b0;
               frame_err_d = 1'b0;
               state_d     = StStart;
            end
         end
         StStart: begin
            if (sample) begin
               if (rx_s_q) begin
                  state_d = StIdle;
               end else begin
                  bit_idx_d = '0;
                  state_d   = StData;
               end
            end
         end
         StData: begin
            if (sample) begin
               shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
               if (bit_idx_q == 4'(DATA_WIDTH - 1)) begin
                  stop_idx_d = 1'b0;
                  state_d    = (parity_q == PAR_NONE) ? StStop : StParity;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         StParity: begin
            if (sample) begin
               par_bit_d = rx_s_q;
               par_err_d = (^shift_q) ^ rx_s_q ^ (parity_q == PAR_ODD);
               state_d   = StStop;
            end
         end
         StStop: begin
            if (sample) begin
               if (two_stop_q && !stop_idx_q) begin
                  frame_err_d = frame_err_now;
                  stop_idx_d  = 1'b1;
               end else if (frame_err_now && (shift_q == '0) && !par_bit_q) begin
                  brk     = 1'b1;
                  state_d = StBreakWait;
               end else begin
                  push    = 1'b1;
                  state_d = frame_err_now ? StBreakWait : StIdle;
               end
            end
         end
         StBreakWait: begin
            if (rx_s_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         prescale_q  <= PW'(PRESCALE_MIN);
         parity_q    <= PAR_NONE;
         two_stop_q  <= 1'b0;
         bit_idx_q   <= '0;
         stop_idx_q  <= 1'b0;
         shift_q     <= '0;
         par_bit_q   <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prescale_q  <= prescale_d;
         parity_q    <= parity_d;
         two_stop_q  <= two_stop_d;
         bit_idx_q   <= bit_idx_d;
         stop_idx_q  <= stop_idx_d;
         shift_q     <= shift_d;
         par_bit_q   <= par_bit_d;
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      push_word                               = '0;
      push_word[DATA_WIDTH-1:0]               = shift_q;
      push_word[DATA_WIDTH + TUSER_PARITY]    = par_err_q;
      push_word[DATA_WIDTH + TUSER_FRAME]     = frame_err_now;
   end

   uart_fifo #(
      .WIDTH (WordWidth),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .wdata_i     (push_word),
      .push_ok_o   (push_ok),
      .pop_ready_i (m_axis_tready),
      .rdata_o     (head_word),
      .valid_o     (m_axis_tvalid),
      .count_o     (fifo_count_o)
   );

   assign m_axis_tdata    = head_word[DATA_WIDTH-1:0];
   assign m_axis_tuser    = head_word[WordWidth-1:DATA_WIDTH];
   assign busy_o          = (state_q != StIdle);
   assign overrun_error_o = push & ~push_ok;
   assign parity_error_o  = push & par_err_q;
   assign frame_error_o   = push & frame_err_now;
   assign break_o         = brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a frame-level model queues expected words and event
// counts; a monitor pops and compares every word the DUT hands over.
module tb_uart_rx_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PW    = 16;

   logic          clk, rst, rx;
   logic [PW-1:0] prescale;
   logic [1:0]    pmode;
   logic          stop_bits;
   logic [DW-1:0] tdata;
   logic [1:0]    tuser;
   logic          tvalid, tready;
   logic          busy, ovr_o, par_o, frm_o, brk_o;
   logic [4:0]    count;

   int checks = 0;
   int failures = 0;
   int n_par = 0, n_frm = 0, n_brk = 0, n_ovr = 0;
   int exp_par = 0, exp_frm = 0, exp_brk = 0, exp_ovr = 0;
   logic [9:0] exp_q[$];
   logic [9:0] exp_w;
   bit   model_track = 0;
   int   model_occ = 0;
   bit   rand_ready = 0;
   int   lat_n;

   uart_rx_fifo #(
      .DATA_WIDTH     (DW),
      .FIFO_DEPTH     (DEPTH),
      .PRESCALE_WIDTH (PW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .rx_i            (rx),
      .prescale_i      (prescale),
      .parity_mode_i   (pmode),
      .stop_bits_i     (stop_bits),
      .m_axis_tdata    (tdata),
      .m_axis_tuser    (tuser),
      .m_axis_tvalid   (tvalid),
      .m_axis_tready   (tready),
      .busy_o          (busy),
      .overrun_error_o (ovr_o),
      .parity_error_o  (par_o),
      .frame_error_o   (frm_o),
      .break_o         (brk_o),
      .fifo_count_o    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every accepted word must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && tvalid && tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", {tuser, tdata});
         end else begin
            exp_w = exp_q.pop_front();
            check("rx_word", {22'd0, tuser, tdata}, {22'd0, exp_w});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (par_o) n_par++;
         if (frm_o) n_frm++;
         if (brk_o) n_brk++;
         if (ovr_o) n_ovr++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Frame-level reference: what a receiver must report for the given serial frame.
   task automatic expect_frame(input logic [7:0] d, input logic [1:0] mode, input bit p,
                               input bit two, input bit s1, input bit s2);
      bit par_en, pe, fe, brk;
      par_en = (mode == 2'b01) || (mode == 2'b10);
      pe = 1'b0;
      if (par_en) begin
         if (mode == 2'b01) pe = (($countones(d) + int'(p)) % 2) != 0;
         else               pe = (($countones(d) + int'(p)) % 2) == 0;
      end
      fe  = !s1 || (two && !s2);
      brk = fe && (d == 8'd0) && !(par_en && p);
      if (brk) begin
         exp_brk++;
      end else begin
         if (pe) exp_par++;
         if (fe) exp_frm++;
         if (model_track && model_occ >= int'(DEPTH)) begin
            exp_ovr++;
         end else begin
            exp_q.push_back({fe, pe, d});
            if (model_track) model_occ++;
         end
      end
   endtask

   task automatic hold_bit(input logic v, input int unsigned p);
      rx = v;
      repeat (p) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input int unsigned pre, input logic [1:0] mode,
                             input bit two, input bit p, input bit s1, input bit s2);
      int unsigned pe_eff;
      pe_eff    = (pre < 4) ? 4 : pre;
      prescale  = PW'(pre);
      pmode     = mode;
      stop_bits = two;
      expect_frame(d, mode, p, two, s1, s2);
      hold_bit(1'b1, 1);
      hold_bit(1'b0, pe_eff);
      // Settings are latched at the start bit; scramble them to prove it.
      prescale  = PW'($urandom);
      pmode     = 2'($urandom);
      stop_bits = 1'($urandom);
      for (int i = 0; i < 8; i++) hold_bit(d[i], pe_eff);
      if (mode == 2'b01 || mode == 2'b10) hold_bit(p, pe_eff);
      hold_bit(s1, pe_eff);
      if (two) hold_bit(s2, pe_eff);
      hold_bit(1'b1, 2 * pe_eff);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tvalid) && n < 4000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_remaining", exp_q.size(), 0);
   endtask

   task automatic check_events(input string tag);
      check({tag, "_parity_pulses"},  n_par, exp_par);
      check({tag, "_frame_pulses"},   n_frm, exp_frm);
      check({tag, "_break_pulses"},   n_brk, exp_brk);
      check({tag, "_overrun_pulses"}, n_ovr, exp_ovr);
   endtask

   initial begin
      logic [7:0] d;
      int unsigned pre;
      logic [1:0] mode;
      bit two, p, s1, s2, par_ok;

      rst = 1'b1;
      rx = 1'b1;
      prescale = 16'd16;
      pmode = 2'b00;
      stop_bits = 1'b0;
      tready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tvalid", tvalid, 0);
      check("reset_tdata",  tdata, 0);
      check("reset_tuser",  tuser, 0);
      check("reset_busy",   busy, 0);
      check("reset_count",  count, 0);
      rst = 1'b0;
      tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: 8N1 0xA5 with latency measurement
      fork
         send_frame(8'hA5, 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
         begin
            lat_n = 0;
            @(negedge rx);
            while (!tvalid && lat_n < 1000) begin
               @(posedge clk);
               #1;
               lat_n++;
            end
            check("latency", lat_n, 2 + 8 + 9 * 16 + 1);
            @(posedge clk);
            #1;
            check("tvalid_one_cycle", tvalid, 0);
         end
      join
      wait_drain();
      check_events("t1");

      // 2: 8E1 0x03 with wrong parity bit
      send_frame(8'h03, 16, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_drain();
      check("t2_parity_pulse", n_par, 1);
      check_events("t2");

      // 3: start-bit glitch
      prescale = 16'd16;
      pmode = 2'b00;
      stop_bits = 1'b0;
      hold_bit(1'b0, 5);
      check("glitch_busy_high", busy, 1);
      hold_bit(1'b1, 32);
      check("glitch_busy_low", busy, 0);
      check("glitch_count", count, 0);
      check_events("t3");

      // 4: overflow with consumer stalled, then drain in order
      tready = 1'b0;
      model_track = 1;
      model_occ = 0;
      for (int i = 0; i <= 16; i++) send_frame(8'(i), 16, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      check("full_count", count, 16);
      check("full_tvalid", tvalid, 1);
      check("overrun_pulse", n_ovr, 1);
      model_track = 0;
      tready = 1'b1;
      wait_drain();
      check("drained_tvalid", tvalid, 0);
      check_events("t4");

      // 5: break (line low for 12 bit periods)
      prescale = 16'd16;
      pmode = 2'b00;
      stop_bits = 1'b0;
      hold_bit(1'b0, 12 * 16);
      check("break_busy_held", busy, 1);
      check("break_pulse", n_brk, 1);
      hold_bit(1'b1, 5);
      check("break_busy_released", busy, 0);
      check("break_no_push", count, 0);
      exp_brk++;
      check_events("t5");

      // 6: reset mid-frame, then 8O2 0x5A
      prescale = 16'd16;
      hold_bit(1'b0, 16);
      for (int i = 0; i < 4; i++) hold_bit(1'(i), 16);
      rst = 1'b1;
      rx = 1'b1;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_count", count, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      hold_bit(1'b1, 4);
      send_frame(8'h5A, 16, 2'b10, 1'b1, ~^8'h5A, 1'b1, 1'b1);
      wait_drain();
      check_events("t6");

      // Randomised frames with random consumer stalls
      rand_ready = 1;
      for (int i = 0; i < 30; i++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 7) == 0) d = 8'd0;
         pre    = $urandom_range(0, 20);
         mode   = 2'($urandom_range(0, 3));
         two    = 1'($urandom_range(0, 1));
         par_ok = (mode == 2'b10) ? ~^d : ^d;
         p      = par_ok ^ ($urandom_range(0, 4) == 0);
         s1     = $urandom_range(0, 5) != 0;
         s2     = $urandom_range(0, 5) != 0;
         send_frame(d, pre, mode, two, p, s1, s2);
      end
      rand_ready = 0;
      tready = 1'b1;
      wait_drain();
      check_events("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
